// File: rtl/config_ser_writer_pkg.sv
// config_pkg: shared constants and types for the configuration serial writer.
//   CFG_ADR_W / CFG_DAT_W : register bank address and data widths
//   CFG_FRM_LEN           : serial frame length in bits (address + data)
//   CFG_CNT_MAX           : saturation value of the frame bit counter
//   wr_state_t            : write sequencer states
//   phase_load()          : converts a phase length in cycles to a timer preload
package config_pkg;

   localparam int CFG_ADR_W   = 2;
   localparam int CFG_DAT_W   = 16;
   localparam int CFG_FRM_LEN = 18;
   localparam int CFG_CNT_W   = 5;
   localparam logic [CFG_CNT_W-1:0] CFG_CNT_MAX = 5'd19;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_SETUP  = 2'd1,
      WR_STROBE = 2'd2,
      WR_HOLD   = 2'd3
   } wr_state_t;

   // The phase timer counts down to zero, so a phase of N cycles loads N-1.
   function automatic logic [2:0] phase_load(input int cyc);
      return 3'(cyc - 1);
   endfunction

endpackage

// File: rtl/config_ser_writer_if.sv
// config_ser_writer_if: write port of the 4x16 configuration register bank.
//   reg_wr  : write strobe, bank captures on its rising edge
//   reg_adr : register address
//   reg_dat : register data
// Modports: master (the writer drives), slave (the bank / observer listens).
interface config_ser_writer_if;
   import config_pkg::*;

   logic                 reg_wr;
   logic [CFG_ADR_W-1:0] reg_adr;
   logic [CFG_DAT_W-1:0] reg_dat;

   modport master (output reg_wr, output reg_adr, output reg_dat);
   modport slave  (input  reg_wr, input  reg_adr, input  reg_dat);

endinterface

// File: rtl/config_ser_writer_sync_edge.sv
// sync_edge: STAGES-deep synchronizer followed by one delay flop used for
// edge detection. All flops reset asynchronously to RST_VAL so that no
// spurious edge is reported when reset is released.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : single-cycle edge indications (derived from two flops)
module sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              dly_r;

   // Synchronizer chain plus the edge-detect delay flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{RST_VAL}};
         dly_r  <= RST_VAL;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
         dly_r  <= sync_r[STAGES-1];
      end
   end

   assign q    = sync_r[STAGES-1];
   assign rise = sync_r[STAGES-1] & ~dly_r;
   assign fall = ~sync_r[STAGES-1] & dly_r;

endmodule

// File: rtl/config_ser_writer.sv
// config_ser_writer: receives 18-bit frames (A1,A0,D15..D0, MSB first) over a
// 3-wire serial link, oversampled in clk_i, and issues one timed write
// (setup / strobe / hold) to the configuration register bank per valid frame.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   ser_csn_i      : frame select, active-low
//   ser_clk_i      : serial bit clock, data sampled on its rising edge
//   ser_dat_i      : serial data
//   wr             : bank write port (reg_wr / reg_adr / reg_dat)
//   busy_o         : a write sequence is in progress
//   frm_err_o      : one-cycle pulse when a frame is discarded
module config_ser_writer
   import config_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SETUP_CYC   = 2,
   parameter int STROBE_CYC  = 2,
   parameter int HOLD_CYC    = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        ser_csn_i,
   input  logic                        ser_clk_i,
   input  logic                        ser_dat_i,
   config_ser_writer_if.master         wr,
   output logic                        busy_o,
   output logic                        frm_err_o
);

   localparam logic [2:0] SETUP_LD  = phase_load(SETUP_CYC);
   localparam logic [2:0] STROBE_LD = phase_load(STROBE_CYC);
   localparam logic [2:0] HOLD_LD   = phase_load(HOLD_CYC);

   logic csn_q_s, csn_rise_s, csn_fall_s;
   logic clk_q_s, clk_rise_s, clk_fall_s;
   logic dat_q_s, dat_rise_s, dat_fall_s;
   logic unused_s;

   logic [CFG_CNT_W-1:0]   bit_cnt_r;
   logic [CFG_FRM_LEN-1:0] shift_r;
   wr_state_t              state_r, state_n;
   logic [2:0]             tmr_r, tmr_n;
   logic                   commit_s, err_s;
   logic                   reg_wr_r, busy_r, frm_err_r;
   logic [CFG_ADR_W-1:0]   reg_adr_r;
   logic [CFG_DAT_W-1:0]   reg_dat_r;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
      .clk(clk_i), .rst_n(rst_n_i), .d(ser_csn_i),
      .q(csn_q_s), .rise(csn_rise_s), .fall(csn_fall_s));
   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk (
      .clk(clk_i), .rst_n(rst_n_i), .d(ser_clk_i),
      .q(clk_q_s), .rise(clk_rise_s), .fall(clk_fall_s));
   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dat (
      .clk(clk_i), .rst_n(rst_n_i), .d(ser_dat_i),
      .q(dat_q_s), .rise(dat_rise_s), .fall(dat_fall_s));

   assign unused_s = &{1'b0, clk_q_s, clk_fall_s, dat_rise_s, dat_fall_s};

   // Frame capture. csn_q_s is already high in the cycle its rise is detected,
   // so a coinciding ser_clk rise is neither shifted nor counted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bit_cnt_r <= 5'd0;
         shift_r   <= 18'd0;
      end else if (csn_fall_s) begin
         bit_cnt_r <= 5'd0;
         shift_r   <= 18'd0;
      end else if (clk_rise_s && !csn_q_s) begin
         shift_r <= {shift_r[CFG_FRM_LEN-2:0], dat_q_s};
         if (bit_cnt_r != CFG_CNT_MAX) begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
         end
      end
   end

   // A frame commits only if it is exactly 18 bits and no write is running;
   // every other frame end is dropped and flagged.
   assign commit_s = csn_rise_s && (bit_cnt_r == 5'(CFG_FRM_LEN)) && (state_r == WR_IDLE);
   assign err_s    = csn_rise_s && !commit_s;

   // Write sequencer next state; one down-counter times every phase.
   always_comb begin
      state_n = state_r;
      tmr_n   = tmr_r;
      case (state_r)
         WR_IDLE: begin
            if (commit_s) begin
               state_n = WR_SETUP;
               tmr_n   = SETUP_LD;
            end else begin
               state_n = WR_IDLE;
               tmr_n   = 3'd0;
            end
         end
         WR_SETUP: begin
            if (tmr_r == 3'd0) begin
               state_n = WR_STROBE;
               tmr_n   = STROBE_LD;
            end else begin
               tmr_n   = tmr_r - 3'd1;
            end
         end
         WR_STROBE: begin
            if (tmr_r == 3'd0) begin
               state_n = WR_HOLD;
               tmr_n   = HOLD_LD;
            end else begin
               tmr_n   = tmr_r - 3'd1;
            end
         end
         WR_HOLD: begin
            if (tmr_r == 3'd0) begin
               state_n = WR_IDLE;
               tmr_n   = 3'd0;
            end else begin
               tmr_n   = tmr_r - 3'd1;
            end
         end
         default: begin
            state_n = WR_IDLE;
            tmr_n   = 3'd0;
         end
      endcase
   end

   // State register and outputs. Outputs are decoded from the next state so
   // they line up with the state they describe without a combinational path.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r   <= WR_IDLE;
         tmr_r     <= 3'd0;
         reg_wr_r  <= 1'b0;
         busy_r    <= 1'b0;
         frm_err_r <= 1'b0;
         reg_adr_r <= 2'd0;
         reg_dat_r <= 16'd0;
      end else begin
         state_r   <= state_n;
         tmr_r     <= tmr_n;
         reg_wr_r  <= (state_n == WR_STROBE);
         busy_r    <= (state_n != WR_IDLE);
         frm_err_r <= err_s;
         if (commit_s) begin
            reg_adr_r <= shift_r[CFG_FRM_LEN-1 -: CFG_ADR_W];
            reg_dat_r <= shift_r[CFG_DAT_W-1:0];
         end
      end
   end

   assign wr.reg_wr  = reg_wr_r;
   assign wr.reg_adr = reg_adr_r;
   assign wr.reg_dat = reg_dat_r;
   assign busy_o     = busy_r;
   assign frm_err_o  = frm_err_r;

endmodule

// File: tb/tb_config_ser_writer.sv
// tb_config_ser_writer: directed bench for config_ser_writer. Instance a uses
// default timing (2/2/2); instance b uses 7/7/7 for the busy-collision case.
// Both share the serial inputs and reset.
module tb_config_ser_writer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic csn = 1'b1;
   logic sclk = 1'b0;
   logic sdat = 1'b0;
   logic busy_a, err_a, busy_b, err_b;

   config_ser_writer_if wa ();
   config_ser_writer_if wb ();

   config_ser_writer dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .ser_csn_i(csn), .ser_clk_i(sclk), .ser_dat_i(sdat),
      .wr(wa), .busy_o(busy_a), .frm_err_o(err_a));

   config_ser_writer #(.SYNC_STAGES(2), .SETUP_CYC(7), .STROBE_CYC(7), .HOLD_CYC(7)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .ser_csn_i(csn), .ser_clk_i(sclk), .ser_dat_i(sdat),
      .wr(wb), .busy_o(busy_b), .frm_err_o(err_b));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Monitors (sampled on the falling edge, away from the active edge).
   logic        wr_prev_a = 1'b0, wr_prev_b = 1'b0, busy_prev_a = 1'b0;
   int          wr_rise_a = 0, wr_rise_b = 0, err_cyc_a = 0, err_cyc_b = 0;
   int          busy_cyc_b = 0, stab_err_a = 0;
   logic [1:0]  hold_adr = 2'd0;
   logic [15:0] hold_dat = 16'd0;
   logic [15:0] obs_bank [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
   logic [15:0] exp_bank [4] = '{16'd0, 16'd0, 16'd0, 16'd0};

   always @(negedge clk) begin
      wr_prev_a   <= wa.reg_wr;
      wr_prev_b   <= wb.reg_wr;
      busy_prev_a <= busy_a;
      if (wa.reg_wr && !wr_prev_a) begin
         wr_rise_a <= wr_rise_a + 1;
         obs_bank[wa.reg_adr] <= wa.reg_dat;
      end
      if (wb.reg_wr && !wr_prev_b) wr_rise_b <= wr_rise_b + 1;
      if (err_a) err_cyc_a <= err_cyc_a + 1;
      if (err_b) err_cyc_b <= err_cyc_b + 1;
      if (busy_b) busy_cyc_b <= busy_cyc_b + 1;
      if (busy_a) begin
         if (!busy_prev_a) begin
            hold_adr <= wa.reg_adr;
            hold_dat <= wa.reg_dat;
         end else if (wa.reg_adr !== hold_adr || wa.reg_dat !== hold_dat) begin
            stab_err_a <= stab_err_a + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends nbits of frm MSB first; with coincide set, one extra ser_clk rise
   // is issued together with the ser_csn rise. Returns right after csn rises.
   task automatic send_frame(input logic [17:0] frm, input int nbits, input bit coincide);
      sclk = 1'b0;
      csn  = 1'b0;
      cyc(3);
      for (int i = 0; i < nbits; i++) begin
         sdat = (i < 18) ? frm[17-i] : 1'b0;
         cyc(3);
         sclk = 1'b1;
         cyc(3);
         sclk = 1'b0;
      end
      cyc(3);
      if (coincide) begin
         sclk = 1'b1;
         csn  = 1'b1;
      end else begin
         csn  = 1'b1;
      end
   endtask

   // Cycles from the csn rise until busy is seen; bounded.
   task automatic wait_busy(input string tag, input bit use_b);
      int k;
      k = 0;
      for (int j = 1; j <= 20; j++) begin
         @(posedge clk);
         @(negedge clk);
         if ((use_b ? busy_b : busy_a) === 1'b1) begin
            k = j;
            break;
         end
      end
      chk(tag, 32'(k), 32'd3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] wr_vec, busy_vec;
      int wrb0, errb0, busyb0;

      // Reset state
      cyc(3);
      chk("rst_wr",   32'(wa.reg_wr),  32'd0);
      chk("rst_adr",  32'(wa.reg_adr), 32'd0);
      chk("rst_dat",  32'(wa.reg_dat), 32'd0);
      chk("rst_busy", 32'(busy_a),     32'd0);
      chk("rst_err",  32'(err_a),      32'd0);
      rst_n = 1'b1;
      cyc(3);

      // Basic frame A=2 D=A5C3
      send_frame({2'd2, 16'hA5C3}, 18, 1'b0);
      wait_busy("basic_lat", 1'b0);
      chk("basic_adr", 32'(wa.reg_adr), 32'd2);
      chk("basic_dat", 32'(wa.reg_dat), 32'hA5C3);
      for (int i = 0; i < 8; i++) begin
         wr_vec[i]   = wa.reg_wr;
         busy_vec[i] = busy_a;
         @(negedge clk);
      end
      chk("basic_wr_shape",   32'(wr_vec),   32'h0C);
      chk("basic_busy_shape", 32'(busy_vec), 32'h3F);
      exp_bank[2] = 16'hA5C3;
      cyc(3);
      chk("basic_err",  32'(err_cyc_a), 32'd0);
      chk("basic_nwr",  32'(wr_rise_a), 32'd1);
      chk("basic_bank", 32'(obs_bank[2]), 32'(exp_bank[2]));

      // Short (17) and long (19) frames
      send_frame({2'd1, 16'h0F0F}, 17, 1'b0);
      cyc(10);
      chk("short_err", 32'(err_cyc_a), 32'd1);
      chk("short_nwr", 32'(wr_rise_a), 32'd1);
      chk("short_adr", 32'(wa.reg_adr), 32'd2);
      chk("short_dat", 32'(wa.reg_dat), 32'hA5C3);
      send_frame({2'd3, 16'hF0F0}, 19, 1'b0);
      cyc(10);
      chk("long_err", 32'(err_cyc_a), 32'd2);
      chk("long_nwr", 32'(wr_rise_a), 32'd1);
      chk("long_adr", 32'(wa.reg_adr), 32'd2);
      chk("long_dat", 32'(wa.reg_dat), 32'hA5C3);

      // Back-to-back frames with minimum csn high time
      for (int a = 0; a < 4; a++) begin
         send_frame({2'(a), 16'(16'h1111 * (a + 1))}, 18, 1'b0);
         exp_bank[a] = 16'(16'h1111 * (a + 1));
         cyc(3);
      end
      cyc(20);
      chk("b2b_nwr",  32'(wr_rise_a),  32'd5);
      chk("b2b_stab", 32'(stab_err_a), 32'd0);
      chk("b2b_err",  32'(err_cyc_a),  32'd2);
      for (int a = 0; a < 4; a++) begin
         chk($sformatf("b2b_bank%0d", a), 32'(obs_bank[a]), 32'(exp_bank[a]));
      end
      chk("b2b_adr", 32'(wa.reg_adr), 32'd3);
      chk("b2b_dat", 32'(wa.reg_dat), 32'h4444);

      // Edge coincidence after 18 bits: commit
      send_frame({2'd1, 16'hBEEF}, 18, 1'b1);
      cyc(10);
      exp_bank[1] = 16'hBEEF;
      chk("coin18_adr",  32'(wa.reg_adr), 32'd1);
      chk("coin18_dat",  32'(wa.reg_dat), 32'hBEEF);
      chk("coin18_nwr",  32'(wr_rise_a),  32'd6);
      chk("coin18_err",  32'(err_cyc_a),  32'd2);
      chk("coin18_bank", 32'(obs_bank[1]), 32'(exp_bank[1]));
      // Edge coincidence after 17 bits: error
      send_frame({2'd2, 16'h0001}, 17, 1'b1);
      cyc(10);
      chk("coin17_err", 32'(err_cyc_a),  32'd3);
      chk("coin17_nwr", 32'(wr_rise_a),  32'd6);
      chk("coin17_adr", 32'(wa.reg_adr), 32'd1);

      // Reset during STROBE
      send_frame({2'd0, 16'h1234}, 18, 1'b0);
      wait_busy("rstmid_lat", 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rstmid_pre_wr", 32'(wa.reg_wr), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_wr",   32'(wa.reg_wr),  32'd0);
      chk("rstmid_adr",  32'(wa.reg_adr), 32'd0);
      chk("rstmid_dat",  32'(wa.reg_dat), 32'd0);
      chk("rstmid_busy", 32'(busy_a),     32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      send_frame({2'd1, 16'hFFFF}, 18, 1'b0);
      cyc(20);
      exp_bank[1] = 16'hFFFF;
      chk("post_rst_adr",  32'(wa.reg_adr), 32'd1);
      chk("post_rst_dat",  32'(wa.reg_dat), 32'hFFFF);
      chk("post_rst_nwr",  32'(wr_rise_a),  32'd7);
      chk("post_rst_bank", 32'(obs_bank[1]), 32'(exp_bank[1]));

      // Busy collision on the 7/7/7 instance. A real 18-bit frame cannot fit
      // inside a 21-cycle write, so a second frame end is produced by a short
      // csn pulse with the bit counter forced to a complete count.
      cyc(40);
      wrb0   = wr_rise_b;
      errb0  = err_cyc_b;
      busyb0 = busy_cyc_b;
      send_frame({2'd3, 16'h5A5A}, 18, 1'b0);
      wait_busy("coll_lat", 1'b1);
      cyc(1);
      csn = 1'b0;
      cyc(4);
      force dut_b.bit_cnt_r = 5'd18;
      cyc(1);
      release dut_b.bit_cnt_r;
      csn = 1'b1;
      cyc(40);
      chk("coll_nwr",  32'(wr_rise_b - wrb0),    32'd1);
      chk("coll_err",  32'(err_cyc_b - errb0),   32'd1);
      chk("coll_busy", 32'(busy_cyc_b - busyb0), 32'd21);
      chk("coll_adr",  32'(wb.reg_adr), 32'd3);
      chk("coll_dat",  32'(wb.reg_dat), 32'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
